spi_cmd_if: RTL and testbench
=============================

SPI_CMD_IF -- requirements
Module: spi_cmd_if

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: i_sys_clk (FPGA clock) and i_rst_b (FPGA reset).
REQ-002 Ports (name  direction  width  meaning):
- i_sys_clk  in  1  system clock.
- i_rst_b  in  1  async active-low reset.
- i_spi_sck  in  1  SPI clock, mode 0, asynchronous to i_sys_clk.
- i_spi_mosi  in  1  SPI data from host.
- i_spi_cs_n  in  1  SPI chip select, active-low.
- o_spi_miso  out  1  SPI data to host.
- o_ioc  out  5  register address to modules.
- o_data_out  out  8  write data to modules.
- o_cs  out  4  one-hot module select.
- o_fetch_cmd  out  1  one-cycle read strobe.
- o_load_cmd  out  1  one-cycle write strobe.
- i_data_mod0 .. i_data_mod3  in  8 each  read-back data from modules 0..3.
REQ-003 Parameter: SYNC_STAGES, default 2, synchronizer depth for sck/mosi/cs_n.

Function
REQ-004 sck, mosi and cs_n SHALL pass through SYNC_STAGES flops; SCK edges are detected on the synchronized signal, one i_sys_clk cycle after synchronization.
REQ-005 Supported SCK frequency SHALL be at most i_sys_clk/16.
REQ-006 Frame: byte 0 = command (MSB first), bit7 = 1 write / 0 read, bits6:5 = module index, bits4:0 = ioc; byte 1 = data (MSB first); bytes after byte 1 are ignored until cs_n rises.
REQ-007 MOSI SHALL be sampled on each detected SCK rise; a 3-bit counter wraps 7->0 at each byte boundary.
REQ-008 States: IDLE, CMD, FETCH, RDWAIT, DATA, LOAD, END.
REQ-009 IDLE->CMD on synchronized cs_n low; the counter and shift registers clear on entry to CMD.
REQ-010 CMD: on the 8th rise, latch o_ioc and o_cs (one-hot of bits6:5); read -> FETCH, write -> DATA.
REQ-011 FETCH: o_fetch_cmd=1 for exactly one cycle, o_cs held; -> RDWAIT.
REQ-012 RDWAIT: one cycle; at its end, the tx shift register loads i_data_modN for the selected N; -> DATA.
REQ-013 DATA: read -> o_spi_miso updates to the next tx bit on each detected SCK fall, with bit7 driven on entry to DATA; write -> o_spi_miso=0; on the 8th rise, write -> LOAD, read -> END.
REQ-014 LOAD: o_data_out = received byte, stable from this cycle until the next LOAD; o_load_cmd=1 for exactly one cycle, o_cs held; -> END.
REQ-015 END: ignore SCK; o_spi_miso=0; -> IDLE on cs_n high.
REQ-016 cs_n high in any non-IDLE state SHALL force IDLE next cycle, including a LOAD not yet entered; an incomplete write byte SHALL never produce o_load_cmd.
REQ-017 o_cs SHALL be 0 in IDLE and CMD, and hold its value from decode until IDLE.
REQ-018 o_fetch_cmd and o_load_cmd SHALL never both be asserted, and each SHALL be asserted at most once per frame.
REQ-019 o_spi_miso SHALL be 0 in IDLE and CMD.

Reset
REQ-020 While i_rst_b=0, the block SHALL be in state IDLE with these values: o_spi_miso=0, o_ioc=0, o_data_out=0, o_cs=0, o_fetch_cmd=0, o_load_cmd=0, counters=0, synchronizers=idle (cs_n=1, sck=0).
REQ-021 Reset asserted mid-frame SHALL abort without strobes; after release, the block waits for a fresh cs_n low, and a frame already in progress is not resumed until cs_n has been seen high.

Verification
REQ-022 Write: frame 0xA3,0x5C -> one o_load_cmd pulse, o_cs=0010, o_ioc=0x03, o_data_out=0x5C; no fetch.
REQ-023 Read: frame 0x02,0x00 with i_data_mod0=0x01 -> one o_fetch_cmd pulse, o_cs=0001, o_ioc=0x02; MISO byte 1 = 0x01.
REQ-024 Abort: write 0xE1 then 4 data bits, then cs_n high -> no o_load_cmd; IDLE; next frame decodes normally.
REQ-025 Long frame: write 0x81,0x11,0xFF,0xFF -> exactly one load, o_data_out=0x11; MISO=0 throughout.
REQ-026 Reset mid-DATA: i_rst_b low for 3 cycles -> all outputs 0; held-low cs_n does not start a frame until toggled high then low.
REQ-027 Back-to-back: reads to modules 3 and 1, with 1 SCK period of cs_n high between them, at SCK=sys_clk/16 -> correct MISO bytes 0xC3 and 0x3C from i_data_mod3 and i_data_mod1.

Source files
------------

// File: rtl/spi_cmd_if.sv
// spi_cmd_if: SPI mode-0 slave command interface. Byte 0 selects a module and
// a register address and gives the direction. Byte 1 carries the write data,
// or returns the module's read data on MISO. At most one strobe is issued per
// chip-select frame.
module spi_cmd_if #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_sys_clk,
    input  logic       i_rst_b,
    input  logic       i_spi_sck,
    input  logic       i_spi_mosi,
    input  logic       i_spi_cs_n,
    output logic       o_spi_miso,
    output logic [4:0] o_ioc,
    output logic [7:0] o_data_out,
    output logic [3:0] o_cs,
    output logic       o_fetch_cmd,
    output logic       o_load_cmd,
    input  logic [7:0] i_data_mod0,
    input  logic [7:0] i_data_mod1,
    input  logic [7:0] i_data_mod2,
    input  logic [7:0] i_data_mod3
);

    // state    | meaning
    // S_IDLE   | waiting for cs_n low (only after cs_n has been seen high)
    // S_CMD    | shifting in the command byte
    // S_FETCH  | read strobe to the selected module
    // S_RDWAIT | module read data settles, loaded into the tx shifter
    // S_DATA   | second byte: receive write data or shift out read data
    // S_LOAD   | write strobe with the received byte
    // S_END    | frame complete, ignore SCK until cs_n rises
    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_FETCH,
        S_RDWAIT,
        S_DATA,
        S_LOAD,
        S_END
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_n_sync;
    logic [SYNC_STAGES:0]   sync_fill;
    logic                   sck_s;
    logic                   mosi_s;
    logic                   cs_n_s;
    logic                   sck_d;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   armed;

    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [6:0] tx_shift;
    logic [7:0] rx_byte;
    logic       is_write;
    logic [1:0] mod_sel;
    logic [7:0] rd_data;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_n_s   = cs_n_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign rx_byte  = {rx_shift, mosi_s};

    // Bring the SPI pins into the system clock domain. sync_fill marks when the
    // chains hold real pin values, not their reset values.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_n_sync <= '1;
            sync_fill <= '0;
        end else begin
            sck_sync[0]  <= i_spi_sck;
            mosi_sync[0] <= i_spi_mosi;
            cs_n_sync[0] <= i_spi_cs_n;
            sync_fill[0] <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sck_sync[i]  <= sck_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
                cs_n_sync[i] <= cs_n_sync[i-1];
            end
            for (int i = 1; i <= SYNC_STAGES; i++) begin
                sync_fill[i] <= sync_fill[i-1];
            end
        end
    end

    // SCK edge history, and arming once a genuine cs_n high has been observed.
    // A frame already in progress at reset release is therefore never resumed.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            sck_d <= 1'b0;
            armed <= 1'b0;
        end else begin
            sck_d <= sck_s;
            if (sync_fill[SYNC_STAGES] && cs_n_s) begin
                armed <= 1'b1;
            end
        end
    end

    // Read-back data from the decoded module
    always_comb begin
        rd_data = i_data_mod0;
        unique case (mod_sel)
            2'd0: rd_data = i_data_mod0;
            2'd1: rd_data = i_data_mod1;
            2'd2: rd_data = i_data_mod2;
            2'd3: rd_data = i_data_mod3;
            default: rd_data = i_data_mod0;
        endcase
    end

    // Frame sequencer with registered outputs. cs_n high overrides every state.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            is_write    <= 1'b0;
            mod_sel     <= '0;
            o_spi_miso  <= 1'b0;
            o_ioc       <= '0;
            o_data_out  <= '0;
            o_cs        <= '0;
            o_fetch_cmd <= 1'b0;
            o_load_cmd  <= 1'b0;
        end else begin
            o_fetch_cmd <= 1'b0;
            o_load_cmd  <= 1'b0;
            if (state != S_IDLE && cs_n_s) begin
                state      <= S_IDLE;
                o_cs       <= '0;
                o_spi_miso <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (armed && !cs_n_s) begin
                            state    <= S_CMD;
                            bit_cnt  <= '0;
                            rx_shift <= '0;
                            tx_shift <= '0;
                        end
                    end
                    S_CMD: begin
                        if (sck_rise) begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            rx_shift <= rx_byte[6:0];
                            if (bit_cnt == 3'd7) begin
                                o_ioc    <= rx_byte[4:0];
                                o_cs     <= 4'b0001 << rx_byte[6:5];
                                mod_sel  <= rx_byte[6:5];
                                is_write <= rx_byte[7];
                                if (rx_byte[7]) begin
                                    state <= S_DATA;
                                end else begin
                                    state       <= S_FETCH;
                                    o_fetch_cmd <= 1'b1;
                                end
                            end
                        end
                    end
                    S_FETCH: begin
                        state <= S_RDWAIT;
                    end
                    S_RDWAIT: begin
                        tx_shift   <= rd_data[6:0];
                        o_spi_miso <= rd_data[7];
                        state      <= S_DATA;
                    end
                    S_DATA: begin
                        if (sck_rise) begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            rx_shift <= rx_byte[6:0];
                            if (bit_cnt == 3'd7) begin
                                o_spi_miso <= 1'b0;
                                if (is_write) begin
                                    state      <= S_LOAD;
                                    o_data_out <= rx_byte;
                                    o_load_cmd <= 1'b1;
                                end else begin
                                    state <= S_END;
                                end
                            end
                        // the fall trailing the command byte has bit_cnt 0 and must not shift
                        end else if (sck_fall && !is_write && bit_cnt != 3'd0) begin
                            o_spi_miso <= tx_shift[6];
                            tx_shift   <= {tx_shift[5:0], 1'b0};
                        end
                    end
                    S_LOAD: begin
                        state <= S_END;
                    end
                    S_END: begin
                        state <= S_END;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_if.sv
// tb_spi_cmd_if: drives SPI mode-0 frames into spi_cmd_if. It compares the
// strobes, the decode and the MISO bytes against constant tables, hand-built
// corner sequences and a small frame-level model.
module tb_spi_cmd_if;

    localparam int HALF = 80;  // SCK half period: SCK = sys_clk/16

    logic       i_sys_clk = 1'b0;
    logic       i_rst_b   = 1'b0;
    logic       i_spi_sck = 1'b0;
    logic       i_spi_mosi = 1'b0;
    logic       i_spi_cs_n = 1'b1;
    logic       o_spi_miso;
    logic [4:0] o_ioc;
    logic [7:0] o_data_out;
    logic [3:0] o_cs;
    logic       o_fetch_cmd;
    logic       o_load_cmd;
    logic [7:0] i_data_mod0 = 8'h00;
    logic [7:0] i_data_mod1 = 8'h00;
    logic [7:0] i_data_mod2 = 8'h00;
    logic [7:0] i_data_mod3 = 8'h00;

    always #5 i_sys_clk = ~i_sys_clk;

    spi_cmd_if #(.SYNC_STAGES(2)) dut (
        .i_sys_clk  (i_sys_clk),
        .i_rst_b    (i_rst_b),
        .i_spi_sck  (i_spi_sck),
        .i_spi_mosi (i_spi_mosi),
        .i_spi_cs_n (i_spi_cs_n),
        .o_spi_miso (o_spi_miso),
        .o_ioc      (o_ioc),
        .o_data_out (o_data_out),
        .o_cs       (o_cs),
        .o_fetch_cmd(o_fetch_cmd),
        .o_load_cmd (o_load_cmd),
        .i_data_mod0(i_data_mod0),
        .i_data_mod1(i_data_mod1),
        .i_data_mod2(i_data_mod2),
        .i_data_mod3(i_data_mod3)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int         fetch_cnt = 0;
    int         load_cnt  = 0;
    int         both_cnt  = 0;
    logic [3:0] cs_cap    = '0;
    logic [4:0] ioc_cap   = '0;

    // Strobe monitor: pulse counts and the decode seen while a strobe is high
    always @(negedge i_sys_clk) begin
        if (o_fetch_cmd || o_load_cmd) begin
            cs_cap  = o_cs;
            ioc_cap = o_ioc;
        end
        if (o_fetch_cmd) fetch_cnt++;
        if (o_load_cmd) load_cnt++;
        if (o_fetch_cmd && o_load_cmd) both_cnt++;
    end

    logic [7:0] tx_b[4];
    logic [7:0] rx_b[4];
    int         df, dl, db;

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  data;
        int          nbits;
        logic [31:0] mods;       // {mod3, mod2, mod1, mod0}
        logic        exp_fetch;
        logic        exp_load;
        logic [3:0]  exp_cs;
        logic [4:0]  exp_ioc;
        logic [7:0]  exp_dout;
        logic [7:0]  exp_miso;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_mods(input logic [31:0] m);
        {i_data_mod3, i_data_mod2, i_data_mod1, i_data_mod0} = m;
    endtask

    task automatic shift_bits(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            i_spi_mosi = tx_b[i/8][7-(i%8)];
            #(HALF);
            i_spi_sck = 1'b1;
            rx_b[i/8][7-(i%8)] = o_spi_miso;
            #(HALF);
            i_spi_sck = 1'b0;
        end
    endtask

    task automatic load_tx(input logic [7:0] c, input logic [7:0] d);
        tx_b[0] = c;
        tx_b[1] = d;
        tx_b[2] = 8'hFF;
        tx_b[3] = 8'hFF;
        for (int i = 0; i < 4; i++) rx_b[i] = 8'h00;
    endtask

    task automatic run_frame(input logic [7:0] c, input logic [7:0] d, input int nbits, input int gap);
        int f0, l0, b0;
        load_tx(c, d);
        f0 = fetch_cnt;
        l0 = load_cnt;
        b0 = both_cnt;
        i_spi_cs_n = 1'b0;
        #(HALF);
        shift_bits(nbits);
        #(HALF);
        i_spi_cs_n = 1'b1;
        i_spi_mosi = 1'b0;
        #(gap);
        df = fetch_cnt - f0;
        dl = load_cnt - l0;
        db = both_cnt - b0;
    endtask

    task automatic check_frame(input string tag, input logic exp_fetch, input logic exp_load,
                               input logic [3:0] exp_cs, input logic [4:0] exp_ioc,
                               input logic [7:0] exp_dout, input logic [7:0] exp_miso,
                               input int nbits);
        check({tag, " fetch_pulses"}, df, {31'd0, exp_fetch});
        check({tag, " load_pulses"}, dl, {31'd0, exp_load});
        check({tag, " both_strobes"}, db, 32'd0);
        if (exp_fetch || exp_load) begin
            check({tag, " cs"}, {28'd0, cs_cap}, {28'd0, exp_cs});
            check({tag, " ioc"}, {27'd0, ioc_cap}, {27'd0, exp_ioc});
        end
        check({tag, " data_out"}, {24'd0, o_data_out}, {24'd0, exp_dout});
        check({tag, " miso_byte0"}, {24'd0, rx_b[0]}, 32'd0);
        if (nbits >= 16) begin
            check({tag, " miso_byte1"}, {24'd0, rx_b[1]}, {24'd0, exp_miso});
        end
        check({tag, " miso_tail"}, {16'd0, rx_b[2], rx_b[3]}, 32'd0);
        check({tag, " idle_cs"}, {28'd0, o_cs}, 32'd0);
        check({tag, " idle_miso"}, {31'd0, o_spi_miso}, 32'd0);
    endtask

    logic [7:0]  r_cmd, r_data, dout_model, r_miso;
    logic [31:0] r_mods;
    logic [1:0]  r_idx;
    logic [3:0]  r_cs;
    logic        r_fetch, r_load;
    int          r_bits, r_sel;
    int          f0, l0;

    initial begin
        vecs[0] = '{8'hA3, 8'h5C, 16, 32'h0000_0000, 1'b0, 1'b1, 4'b0010, 5'h03, 8'h5C, 8'h00};
        vecs[1] = '{8'h02, 8'h00, 16, 32'h0000_0001, 1'b1, 1'b0, 4'b0001, 5'h02, 8'h5C, 8'h01};
        vecs[2] = '{8'h5F, 8'h00, 16, 32'h00A5_0000, 1'b1, 1'b0, 4'b0100, 5'h1F, 8'h5C, 8'hA5};
        vecs[3] = '{8'hE0, 8'hFF, 16, 32'h0000_0000, 1'b0, 1'b1, 4'b1000, 5'h00, 8'hFF, 8'h00};
        vecs[4] = '{8'h81, 8'h11, 32, 32'h1234_5678, 1'b0, 1'b1, 4'b0001, 5'h01, 8'h11, 8'h00};
        vecs[5] = '{8'h3C, 8'h00, 24, 32'h5A5A_3C5A, 1'b1, 1'b0, 4'b0010, 5'h1C, 8'h11, 8'h3C};

        // reset state
        #40;
        check("reset outputs", {13'd0, o_spi_miso, o_ioc, o_data_out, o_cs, o_fetch_cmd, o_load_cmd}, 32'd0);
        #60;
        i_rst_b = 1'b1;
        #200;

        // table-driven frames
        for (int v = 0; v < 6; v++) begin
            set_mods(vecs[v].mods);
            run_frame(vecs[v].cmd, vecs[v].data, vecs[v].nbits, 200);
            check_frame($sformatf("vec%0d", v), vecs[v].exp_fetch, vecs[v].exp_load, vecs[v].exp_cs,
                        vecs[v].exp_ioc, vecs[v].exp_dout, vecs[v].exp_miso, vecs[v].nbits);
        end

        // abort: write command plus four data bits, then a normal frame
        set_mods(32'h0);
        run_frame(8'hE1, 8'hA0, 12, 200);
        check_frame("abort", 1'b0, 1'b0, 4'b0000, 5'h00, 8'h11, 8'h00, 12);
        run_frame(8'hA3, 8'h5C, 16, 200);
        check_frame("after_abort", 1'b0, 1'b1, 4'b0010, 5'h03, 8'h5C, 8'h00, 16);

        // reset in the middle of the data byte with cs_n held low
        load_tx(8'hA3, 8'h77);
        f0 = fetch_cnt;
        l0 = load_cnt;
        i_spi_cs_n = 1'b0;
        #(HALF);
        shift_bits(12);
        i_rst_b = 1'b0;
        #10;
        check("midreset outputs", {13'd0, o_spi_miso, o_ioc, o_data_out, o_cs, o_fetch_cmd, o_load_cmd}, 32'd0);
        #20;
        i_rst_b = 1'b1;
        load_tx(8'hA3, 8'h77);
        shift_bits(16);
        #(HALF);
        check("held_cs_n no strobe", fetch_cnt - f0 + load_cnt - l0, 32'd0);
        check("held_cs_n data_out", {24'd0, o_data_out}, 32'd0);
        i_spi_cs_n = 1'b1;
        #200;
        run_frame(8'hA3, 8'h5C, 16, 200);
        check_frame("after_reset", 1'b0, 1'b1, 4'b0010, 5'h03, 8'h5C, 8'h00, 16);

        // back-to-back reads, one SCK period of cs_n high between them
        set_mods(32'hC300_3C00);
        run_frame(8'h65, 8'h00, 16, 2 * HALF);
        check_frame("b2b_mod3", 1'b1, 1'b0, 4'b1000, 5'h05, 8'h5C, 8'hC3, 16);
        run_frame(8'h2A, 8'h00, 16, 200);
        check_frame("b2b_mod1", 1'b1, 1'b0, 4'b0010, 5'h0A, 8'h5C, 8'h3C, 16);

        // random frames against a frame-level model
        dout_model = 8'h5C;
        for (int k = 0; k < 20; k++) begin
            r_cmd  = 8'($urandom);
            r_data = 8'($urandom);
            r_mods = $urandom;
            r_sel  = int'($urandom_range(0, 3));
            r_bits = (r_sel == 0) ? int'($urandom_range(1, 15)) : 8 * (r_sel + 1);
            r_idx  = r_cmd[6:5];
            r_cs   = 4'(1 << r_idx);
            r_fetch = !r_cmd[7] && (r_bits >= 8);
            r_load  = r_cmd[7] && (r_bits >= 16);
            if (r_load) dout_model = r_data;
            r_miso = r_cmd[7] ? 8'h00 : 8'((r_mods >> (8 * r_idx)) & 32'hFF);
            set_mods(r_mods);
            run_frame(r_cmd, r_data, r_bits, 200);
            check_frame($sformatf("rand%0d", k), r_fetch, r_load, r_cs, r_cmd[4:0],
                        dout_model, r_miso, r_bits);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
